// File: rtl/i2c_slave.sv
// I2C target at a fixed 7-bit address. scl/sda are oversampled on clk; writes come out
// as a vout-strobed byte stream, reads fetch bytes through a req/din handshake.
module i2c_slave #(
   parameter logic [6:0] ADDR = 7'b1000001,
   parameter int         FILT = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       scl,
   inout  wire        sda,
   output logic [7:0] dout,
   output logic       vout,
   input  logic [7:0] din,
   output logic       req,
   output logic       start,
   output logic       stop,
   output logic       rw,
   output logic       busy
);
   localparam int CW = (FILT > 1) ? $clog2(FILT) : 1;

   typedef enum logic [2:0] {S_IDLE, S_ADDR, S_AACK, S_WR, S_WACK, S_RD, S_RACK, S_IGN} st_t;

   st_t                r_st, w_nxt;
   logic [1:0]         r_s1, r_s2, r_flt, r_fltd;   // bit 1 = scl, bit 0 = sda
   logic [1:0][CW-1:0] r_fcnt;
   logic [6:0]         r_sh, r_tx;
   logic [2:0]         r_cnt;
   logic [7:0]         r_dout;
   logic               r_oe, r_ackph, r_load, r_vout, r_req, r_start, r_stop, r_rw, r_busy;
   logic               w_rise, w_fall, w_sta, w_sto, w_run, w_hit;
   logic               w_shift, w_last, w_ack_fall, w_req, w_tx_fall;

   // A new level is accepted only after FILT consecutive synchronised samples agree.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s1   <= '1;
         r_s2   <= '1;
         r_flt  <= '1;
         r_fltd <= '1;
         r_fcnt <= '0;
      end else begin
         r_s1   <= {scl, sda};
         r_s2   <= r_s1;
         r_fltd <= r_flt;
         for (int i = 0; i < 2; i++) begin
            if (r_s2[i] == r_flt[i]) r_fcnt[i] <= '0;
            else if (r_fcnt[i] == CW'(FILT - 1)) begin
               r_flt[i]  <= r_s2[i];
               r_fcnt[i] <= '0;
            end else r_fcnt[i] <= r_fcnt[i] + CW'(1);
         end
      end
   end

   assign w_rise = r_flt[1] & ~r_fltd[1];
   assign w_fall = ~r_flt[1] & r_fltd[1];
   assign w_sta  = r_flt[1] & r_fltd[1] & r_fltd[0] & ~r_flt[0];
   assign w_sto  = r_flt[1] & r_fltd[1] & ~r_fltd[0] & r_flt[0];
   assign w_run  = ~w_sta & ~w_sto;
   assign w_hit  = (r_sh == ADDR);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_st <= S_IDLE;
      else     r_st <= w_nxt;
   end

   always_comb begin
      w_nxt = r_st;
      if (w_sta)      w_nxt = S_ADDR;
      else if (w_sto) w_nxt = S_IDLE;
      else begin
         case (r_st)
            S_ADDR:  if (w_rise && r_cnt == 3'd7) w_nxt = w_hit ? S_AACK : S_IGN;
            S_AACK:  if (w_fall && r_ackph) w_nxt = r_rw ? S_RD : S_WR;
            S_WR:    if (w_rise && r_cnt == 3'd7) w_nxt = S_WACK;
            S_WACK:  if (w_fall && r_ackph) w_nxt = S_WR;
            S_RD:    if (w_fall && !r_load && r_cnt == 3'd7) w_nxt = S_RACK;
            S_RACK:  if (w_rise && r_flt[0]) w_nxt = S_IGN;
                     else if (w_fall) w_nxt = S_RD;
            default: w_nxt = r_st;
         endcase
      end
   end

   always_comb begin
      w_shift    = w_run && w_rise && (r_st == S_ADDR || r_st == S_WR);
      w_last     = w_shift && r_cnt == 3'd7;
      w_ack_fall = w_run && w_fall && (r_st == S_AACK || r_st == S_WACK);
      w_req      = w_run && w_fall && ((r_st == S_AACK && r_ackph && r_rw) || r_st == S_RACK);
      w_tx_fall  = w_run && w_fall && r_st == S_RD && !r_load;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sh <= '0; r_tx <= '0; r_cnt <= '0; r_dout <= '0;
         r_oe <= 1'b0; r_ackph <= 1'b0; r_load <= 1'b0; r_vout <= 1'b0; r_req <= 1'b0;
         r_start <= 1'b0; r_stop <= 1'b0; r_rw <= 1'b0; r_busy <= 1'b0;
      end else begin
         r_start <= w_sta;
         r_stop  <= w_sto;
         r_req   <= w_req;
         r_vout  <= 1'b0;
         if (w_sta || w_sto) begin
            r_sh <= '0; r_cnt <= '0;
            r_oe <= 1'b0; r_ackph <= 1'b0; r_load <= 1'b0; r_busy <= 1'b0;
         end else begin
            if (w_shift) begin
               r_sh  <= {r_sh[5:0], r_flt[0]};
               r_cnt <= r_cnt + 3'd1;
            end
            if (w_last && r_st == S_ADDR && w_hit) begin
               r_rw   <= r_flt[0];
               r_busy <= 1'b1;
            end
            if (w_last && r_st == S_WR) begin
               r_dout <= {r_sh, r_flt[0]};
               r_vout <= 1'b1;
            end
            // First fall of an ACK slot pulls sda low, the second one lets go.
            if (w_ack_fall) begin
               r_oe    <= ~r_ackph;
               r_ackph <= ~r_ackph;
            end
            if (w_req) begin
               r_load <= 1'b1;
               r_oe   <= 1'b0;
            end
            if (r_load) begin
               r_tx   <= din[6:0];
               r_oe   <= ~din[7];
               r_load <= 1'b0;
               r_cnt  <= '0;
            end
            if (w_tx_fall) begin
               r_cnt <= r_cnt + 3'd1;
               r_tx  <= {r_tx[5:0], 1'b0};
               r_oe  <= (r_cnt == 3'd7) ? 1'b0 : ~r_tx[6];
            end
         end
      end
   end

   // START/STOP gate the drive combinationally so a repeated START frees the bus at once.
   assign sda   = (r_oe && w_run) ? 1'b0 : 1'bz;
   assign dout  = r_dout;
   assign vout  = r_vout;
   assign req   = r_req;
   assign start = r_start;
   assign stop  = r_stop;
   assign rw    = r_rw;
   assign busy  = r_busy;
endmodule

// File: tb/tb_i2c_slave.sv
// Bit-banged I2C master driving i2c_slave; expectations come from transaction-level
// rules (address match, ACK, byte lists) rather than the block's internals.
module tb_i2c_slave;
   localparam logic [6:0] ADDR = 7'b1000001;
   localparam int Q = 10;

   logic       clk = 1'b0, rst = 1'b1, scl = 1'b1, m_sda = 1'b1;
   wire        sda;
   logic [7:0] dout, din;
   logic       vout, req, start, stop, rw, busy;

   pullup (sda);
   assign sda = m_sda ? 1'bz : 1'b0;

   i2c_slave dut (
      .clk(clk), .rst(rst), .scl(scl), .sda(sda), .dout(dout), .vout(vout), .din(din),
      .req(req), .start(start), .stop(stop), .rw(rw), .busy(busy)
   );

   always #5 clk = ~clk;

   int         n_tot = 0, n_bad = 0;
   int         n_vout = 0, n_req = 0, n_start = 0, n_stop = 0;
   logic [7:0] rx_q[$];
   logic [7:0] din_tab [0:255];
   logic [7:0] wd [0:3];
   logic [7:0] rd [0:3];
   logic       exp_rw = 1'b0;

   // din for the k-th req of the run lives at din_tab[k+1]; the count steps before the latch.
   assign din = din_tab[n_req[7:0]];

   always @(negedge clk) begin
      if (vout)  begin n_vout++; rx_q.push_back(dout); end
      if (req)   n_req++;
      if (start) n_start++;
      if (stop)  n_stop++;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tot++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", tag, got, exp);
      end
   endtask

   task automatic qw();
      repeat (Q) @(posedge clk);
      #1;
   endtask

   task automatic m_start();
      m_sda = 1'b1; qw(); scl = 1'b1; qw(); m_sda = 1'b0; qw(); scl = 1'b0; qw();
   endtask

   task automatic m_stop();
      m_sda = 1'b0; qw(); scl = 1'b1; qw(); m_sda = 1'b1; qw();
   endtask

   task automatic m_bit(input logic b, input logic g, output logic r);
      m_sda = b;
      if (g) begin
         repeat (3) @(posedge clk);
         #1 scl = 1'b1;
         @(posedge clk);
         #1 scl = 1'b0;
      end
      qw(); scl = 1'b1; qw(); r = sda; qw(); scl = 1'b0; qw();
   endtask

   task automatic m_byte(input logic [7:0] d, input int g, output logic ack);
      logic r;
      for (int i = 7; i >= 0; i--) m_bit(d[i], i == g, r);
      m_bit(1'b1, 1'b0, ack);
   endtask

   task automatic m_rbyte(input logic nack, output logic [7:0] d);
      logic r;
      for (int i = 7; i >= 0; i--) begin m_bit(1'b1, 1'b0, r); d[i] = r; end
      m_bit(nack, 1'b0, r);
   endtask

   task automatic do_write(input logic [6:0] a, input int n, input int g);
      logic ack, hit;
      int   v0, s0, p0;
      hit = (a == ADDR);
      v0 = n_vout; s0 = n_start; p0 = n_stop;
      m_start();
      m_byte({a, 1'b0}, -1, ack);
      chk("wr_aack", ack, !hit);
      if (hit) exp_rw = 1'b0;
      chk("wr_busy", busy, hit);
      chk("wr_rw", rw, exp_rw);
      for (int i = 0; i < n; i++) begin
         m_byte(wd[i], (i == 0) ? g : -1, ack);
         chk("wr_dack", ack, !hit);
      end
      m_stop();
      chk("wr_nvout", n_vout - v0, hit ? n : 0);
      if (hit) for (int i = 0; i < n; i++) chk("wr_data", rx_q[v0 + i], wd[i]);
      chk("wr_busy_end", busy, 0);
      chk("wr_nstart", n_start - s0, 1);
      chk("wr_nstop", n_stop - p0, 1);
   endtask

   task automatic do_read(input logic [6:0] a, input int n);
      logic       ack, hit;
      logic [7:0] d;
      int         r0;
      hit = (a == ADDR);
      r0 = n_req;
      for (int i = 0; i < n; i++) din_tab[(n_req + 1 + i) & 255] = rd[i];
      m_start();
      m_byte({a, 1'b1}, -1, ack);
      chk("rd_aack", ack, !hit);
      if (hit) exp_rw = 1'b1;
      chk("rd_busy", busy, hit);
      chk("rd_rw", rw, exp_rw);
      for (int i = 0; i < n; i++) begin
         m_rbyte(i == n - 1, d);
         chk("rd_data", d, hit ? rd[i] : 8'hFF);
      end
      chk("rd_rel", sda, 1'b1);
      m_stop();
      chk("rd_nreq", n_req - r0, hit ? n : 0);
      chk("rd_busy_end", busy, 0);
   endtask

   initial begin
      logic       ack, r;
      logic [7:0] d;
      int         v0, s0, r0;

      repeat (3) @(posedge clk);
      #1;
      chk("rst_sda", sda, 1'b1);
      chk("rst_out", {dout, vout, req, start, stop, rw, busy}, 14'h0);
      rst = 1'b0;
      qw();

      wd[0] = 8'h05; wd[1] = 8'hC5; wd[2] = 8'hDD;
      do_write(ADDR, 3, -1);

      rd[0] = 8'hAB; rd[1] = 8'hCD;
      do_read(ADDR, 2);

      wd[0] = 8'h77;
      do_write(7'b1000010, 1, -1);

      // write 0x12, repeated START, read 0x34
      v0 = n_vout; s0 = n_start; r0 = n_req;
      din_tab[(n_req + 1) & 255] = 8'h34;
      m_start();
      m_byte({ADDR, 1'b0}, -1, ack); chk("rs_aack_w", ack, 1'b0);
      m_byte(8'h12, -1, ack);        chk("rs_dack", ack, 1'b0);
      chk("rs_rw0", rw, 1'b0);
      m_start();
      m_byte({ADDR, 1'b1}, -1, ack); chk("rs_aack_r", ack, 1'b0);
      m_rbyte(1'b1, d);
      chk("rs_rdata", d, 8'h34);
      m_stop();
      exp_rw = 1'b1;
      chk("rs_nvout", n_vout - v0, 1);
      chk("rs_dout", rx_q[v0], 8'h12);
      chk("rs_nstart", n_start - s0, 2);
      chk("rs_rw1", rw, 1'b1);
      chk("rs_nreq", n_req - r0, 1);

      // reset during the 4th data bit of a write
      v0 = n_vout;
      m_start();
      m_byte({ADDR, 1'b0}, -1, ack); chk("rr_aack", ack, 1'b0);
      for (int i = 0; i < 3; i++) m_bit(1'b0, 1'b0, r);
      m_sda = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rr_sda", sda, 1'b1);
      chk("rr_busy", busy, 1'b0);
      rst = 1'b0;
      exp_rw = 1'b0;
      qw(); scl = 1'b1; qw(); qw(); scl = 1'b0; qw();
      for (int i = 0; i < 4; i++) m_bit(1'b0, 1'b0, r);
      m_bit(1'b1, 1'b0, ack);
      chk("rr_noack", ack, 1'b1);
      m_stop();
      chk("rr_nvout", n_vout - v0, 0);
      wd[0] = 8'h3C; wd[1] = 8'hE1;
      do_write(ADDR, 2, -1);

      // single-clk scl glitch inside a data bit
      wd[0] = 8'hA5;
      do_write(ADDR, 1, 3);

      for (int t = 0; t < 10; t++) begin
         logic [6:0] a;
         int         n;
         a = ($urandom_range(0, 3) == 0) ? 7'($urandom) : ADDR;
         n = $urandom_range(1, 3);
         for (int i = 0; i < n; i++) begin
            wd[i] = 8'($urandom);
            rd[i] = 8'($urandom);
         end
         if ($urandom_range(0, 1) == 1) do_read(a, n);
         else do_write(a, n, -1);
      end

      $display("test done: total=%0d bad=%0d", n_tot, n_bad);
      $finish;
   end

   initial begin
      repeat (90000) @(posedge clk);
      $display("FAIL watchdog: run exceeded cycle budget");
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/i2c_slave.md
Name: i2c_slave

Overview:
I2C target (responder) that answers the existing i2c master at a fixed 7-bit address. It oversamples scl/sda on the system clock, detects START/STOP, matches the address and ACKs. On writes it delivers received bytes as a valid-strobed stream; on reads it fetches bytes through a request strobe and shifts them out on sda. It is the bench partner for the master and a reusable register-access front end. It has no clock stretching.

Parameters:
ADDR, 7'b1000001, own 7-bit target address
FILT, 2, glitch filter depth; scl/sda must be stable this many clk cycles after synchronisation before a level change is accepted

Ports:
clk    input   1  system clock
rst    input   1  asynchronous reset, active-high
scl    input   1  I2C clock (pulled up externally; never driven)
sda    inout   1  I2C data, open-drain: drives 0 or 'z only
dout   output  8  received byte, MSB first on bus
vout   output  1  one-cycle strobe, dout valid
din    input   8  byte to transmit on read
req    output  1  one-cycle strobe; din sampled on the next clk
start  output  1  one-cycle strobe on START or repeated START
stop   output  1  one-cycle strobe on STOP
rw     output  1  R/W bit of the current transfer (1 = read)
busy   output  1  high from an address match until STOP or the next START

Behaviour:
- Reset (async): sda released ('z), dout=0, vout=0, req=0, start=0, stop=0, rw=0, busy=0, FSM=IDLE, filters preset to 1.
- Input path: 2-FF synchroniser, then the FILT filter, producing scl_f/sda_f. Edges: scl_rise/scl_fall are 1-cycle pulses.
- START: sda_f falls while scl_f=1. STOP: sda_f rises while scl_f=1. Both are detected in any state and take priority over bit events.
  - START: start pulses, shift register and bit counter cleared, FSM -> ADDR.
  - STOP: stop pulses, sda released, busy=0, FSM -> IDLE.
- Bits are sampled on scl_rise. sda is updated on the cycle after scl_fall.
- FSM:
  - IDLE: wait for START.
  - ADDR: shift 8 bits. After the 8th rise:
    - upper 7 bits == ADDR: rw latched, busy=1, -> ADDR_ACK.
    - otherwise: -> IGNORE. IGNORE releases sda until START/STOP; no vout or req.
  - ADDR_ACK: drive sda=0 from the next scl_fall through the following scl_fall, then release.
    - rw=0 -> WR.
    - rw=1 -> req pulses on the scl_fall that ends the ACK. din is latched one cycle later and the first bit drives immediately -> RD.
  - WR: shift 8 bits. After the 8th rise, dout is loaded and vout pulses on the next clk -> WR_ACK. Every byte is ACKed.
  - WR_ACK: sda=0 for one bit time as in ADDR_ACK -> WR.
  - RD: drive bit 7..0 of the latched byte, each changing after scl_fall. Drive 1 means release. After the 8th bit's fall, release sda -> RD_ACK.
  - RD_ACK: sample sda on scl_rise.
    - 0 (ACK): on the next scl_fall, req pulses, din latched, -> RD.
    - 1 (NACK): -> IGNORE, sda released; busy stays high until STOP/START.
- Bit counter is 3 bits and wraps 7->0 at each byte boundary. There is no limit on byte count.
- Repeated START mid-byte: the partial byte is discarded with no vout, sda released on the same cycle, and the address phase restarts.
- sda is never driven while scl_f=1 except to hold the current bit; a drive change only follows scl_fall.
- Async reset mid-transfer releases sda within the reset cycle. Afterwards the block waits for a fresh START; a transfer in progress is ignored.

Test Plan:
- Write, master PRESCALER=10, addr 7'b1000001 W, data 24'h05C5DD -> ACK on the address and all 3 bytes; vout pulses 3 times with dout 8'h05, 8'hC5, 8'hDD; busy falls one cycle after STOP.
- Write to addr 7'b1000010 -> no ACK (sda stays 1 in the 9th bit), no vout, busy=0, rw unchanged.
- Read 2 bytes, din = 8'hAB then 8'hCD, master ACKs byte 1 and NACKs byte 2 -> bus carries AB, CD; req pulses exactly twice; sda released after byte 2.
- Write 1 byte 8'h12, repeated START, read 1 byte (din 8'h34) -> vout once with 8'h12; start pulses twice; rw goes 0->1; read returns 8'h34.
- rst asserted for 2 cycles during the 4th data bit of a write -> sda released immediately, no vout; the next full transfer completes normally.
- 1-clk glitch on scl during a data byte (FILT=2) -> ignored; byte received correctly.
